// File: rtl/uart_char_rx.sv
// UART 8N1 receiver: synchronises rx, deserialises LSB-first frames and holds each
// character in a one-entry valid/ready register, flagging framing errors and overruns.
module uart_char_rx #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic a0,
    output logic a1,
    output logic a2,
    output logic a3,
    output logic a4,
    output logic a5,
    output logic a6,
    output logic a7,
    output logic out_valid,
    input  logic out_ready,
    output logic frame_err,
    output logic overrun,
    output logic busy
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] HALF_LIM = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LIM = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic            rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [2:0]      bit_r, bit_nxt_s;
    logic [7:0]      shift_r, shift_nxt_s;
    logic [7:0]      data_r, data_nxt_s;
    logic            valid_r, valid_nxt_s;
    logic            ferr_r, ferr_nxt_s;
    logic            ovr_r, ovr_nxt_s;
    logic            busy_r;
    logic            fall_s;

    assign fall_s = rx_prev_r & ~rx_sync_r;

    // Two-flop synchroniser plus a history flop for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Next-state, counters, shift register, holding register and status pulses.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        data_nxt_s  = data_r;
        ferr_nxt_s  = 1'b0;
        ovr_nxt_s   = 1'b0;
        if (valid_r && out_ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                bit_nxt_s = 3'd0;
                if (fall_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LIM) begin
                    cnt_nxt_s = '0;
                    bit_nxt_s = 3'd0;
                    if (!rx_sync_r) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == FULL_LIM) begin
                    cnt_nxt_s   = '0;
                    shift_nxt_s = {rx_sync_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_nxt_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_r == FULL_LIM) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                    if (!rx_sync_r) begin
                        ferr_nxt_s = 1'b1;
                    end else if (!valid_r || out_ready) begin
                        // A load on the handshake edge keeps out_valid high with the new data.
                        data_nxt_s  = shift_r;
                        valid_nxt_s = 1'b1;
                    end else begin
                        ovr_nxt_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
                bit_nxt_s   = 3'd0;
            end
        endcase
    end

    // State and datapath registers; all outputs are driven from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            data_r  <= 8'd0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            ferr_r  <= ferr_nxt_s;
            ovr_r   <= ovr_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    assign {a7, a6, a5, a4, a3, a2, a1, a0} = data_r;
    assign out_valid = valid_r;
    assign frame_err = ferr_r;
    assign overrun   = ovr_r;
    assign busy      = busy_r;

endmodule
